// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - instruction-fetch sequencer with 2-entry fetch FIFO and redirect handling
module if_fetch_ctrl #(
  parameter logic [31:0] PC_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FULL  = 2'd1,
    FAULT = 2'd2
  } state_e;

  // One past the last fetchable byte address; 33 bits so the compare cannot wrap.
  localparam logic [32:0] PC_END = {1'b0, PC_BASE} + 33'(4 * IM_WORDS);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] fifo_pc_q    [2];
  logic [31:0] fifo_instr_q [2];

  logic pop;
  logic push;
  logic in_range;
  logic can_push;

  assign out_valid   = (count_q != 2'd0);
  assign pop         = out_valid & out_ready;
  assign in_range    = (pc_q >= PC_BASE) && ({1'b0, pc_q} < PC_END);
  assign can_push    = (count_q < 2'd2) | pop;
  assign out_instr   = out_valid ? fifo_instr_q[rd_ptr_q] : 32'd0;
  assign out_pc      = out_valid ? fifo_pc_q[rd_ptr_q]    : 32'd0;
  assign im_addr     = pc_q - PC_BASE;
  assign fetch_fault = (state_q == FAULT);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    push     = 1'b0;
    if (redir_valid) begin
      // A pop this cycle is still handshaken, but the flush discards everything.
      state_d  = RUN;
      pc_d     = {redir_target[31:2], 2'b00};
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      unique case (state_q)
        RUN: begin
          if (can_push) begin
            if (in_range) begin
              push     = 1'b1;
              pc_d     = pc_q + 32'd4;
              wr_ptr_d = ~wr_ptr_q;
            end else begin
              state_d = FAULT;
            end
          end
          if (push && !pop && count_q == 2'd1) begin
            state_d = FULL;
          end
        end
        FULL: begin
          // Drain a slot first; fetching resumes the cycle after.
          if (pop) begin
            state_d = RUN;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = RUN;
        end
      endcase
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RUN;
      pc_q     <= PC_BASE;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= pc_q;
      fifo_instr_q[wr_ptr_q] <= im_data;
    end
  end

endmodule
